// File: rtl/mario_pkg.sv
// Shared motion-state encoding and world/screen geometry for the Mario pipeline
// (motion, collision detector and sprite blocks).
package mario_pkg;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } motion_state_e;

  localparam int X_MAX    = 3375;
  localparam int Y_GROUND = 223;
  localparam int SCREEN_W = 320;

  localparam int XW       = 13;
  localparam int YW       = 10;
  localparam int OFFSET_W = 12;

endpackage

// File: rtl/camera_offset.sv
// Registered camera scroll: keeps Mario at screen column CAM_X, clamped to
// the first and last full screens of the world.
module camera_offset
  import mario_pkg::*;
#(
  parameter int CAM_X   = 160,
  parameter int OFF_MAX = 3056
) (
  input  logic                pixel_clk_in,
  input  logic                rst_in,
  input  logic [XW-1:0]       x_in,
  output logic [OFFSET_W-1:0] offset_out
);

  localparam logic signed [13:0] CAM_S     = 14'(CAM_X);
  localparam logic signed [13:0] OFF_MAX_S = 14'(OFF_MAX);

  logic signed [13:0]    diff;
  logic [OFFSET_W-1:0]   offset_d;
  logic [OFFSET_W-1:0]   offset_q;

  assign diff = $signed({1'b0, x_in}) - CAM_S;

  always_comb begin
    offset_d = diff[OFFSET_W-1:0];
    if (diff < 14'sd0) begin
      offset_d = '0;
    end else if (diff > OFF_MAX_S) begin
      offset_d = OFF_MAX_S[OFFSET_W-1:0];
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) offset_q <= '0;
    else        offset_q <= offset_d;
  end

  assign offset_out = offset_q;

endmodule

// File: rtl/mario_motion.sv
// Per-frame Mario kinematics: walk, jump/fall FSM with head-bump abort, and
// camera scroll. All positions change only on new_frame so the detector sees stable values.
module mario_motion #(
  parameter int X_START   = 40,
  parameter int X_MAX     = mario_pkg::X_MAX,
  parameter int HALF_W    = 4,
  parameter int Y_GROUND  = mario_pkg::Y_GROUND,
  parameter int Y_MIN     = 16,
  parameter int WALK_STEP = 2,
  parameter int JUMP_V    = 10,
  parameter int VY_MAX    = 8,
  parameter int CAM_X     = 160,
  parameter int SCREEN_W  = mario_pkg::SCREEN_W
) (
  input  logic        pixel_clk_in,
  input  logic        rst_in,
  input  logic        new_frame,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_jump,
  input  logic        head_hit_in,
  output logic [12:0] x_mario_center,
  output logic [9:0]  y_mario_center,
  output logic [11:0] offset,
  output logic [1:0]  state_out,
  output logic        jump_start
);
  import mario_pkg::*;

  localparam logic signed [13:0] X_LO    = 14'(HALF_W);
  localparam logic signed [13:0] X_HI    = 14'(X_MAX - HALF_W);
  localparam logic signed [13:0] STEP    = 14'(WALK_STEP);
  localparam logic [12:0]        X_RST   = 13'(X_START);
  localparam logic [9:0]         Y_GND   = 10'(Y_GROUND);
  localparam logic [9:0]         Y_TOP   = 10'(Y_MIN);
  localparam logic [3:0]         VY_JUMP = 4'(JUMP_V);
  localparam logic [3:0]         VY_TERM = 4'(VY_MAX);

  motion_state_e state_q, state_d;
  logic [12:0]   x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [3:0]    vy_q, vy_d;
  logic          hit_seen_q, hit_seen_d;
  logic          armed_q, armed_d;
  logic          jump_start_q, jump_start_d;

  logic               hit_now;
  logic signed [13:0] x_s;
  logic signed [10:0] y_sub;
  logic [10:0]        y_add;
  logic [3:0]         vy_dec;

  // A hit arriving in the same cycle as new_frame belongs to the frame being closed.
  assign hit_now = hit_seen_q | head_hit_in;
  assign y_sub   = $signed({1'b0, y_q}) - $signed({7'b0, vy_q});
  assign y_add   = {1'b0, y_q} + {7'b0, vy_q};
  assign vy_dec  = vy_q - 4'd1;

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    vy_d         = vy_q;
    armed_d      = armed_q;
    jump_start_d = 1'b0;
    hit_seen_d   = hit_now;
    x_s          = $signed({1'b0, x_q});

    if (new_frame) begin
      hit_seen_d = 1'b0;
      armed_d    = armed_q | ~btn_jump;

      if (btn_right && !btn_left)      x_s = x_s + STEP;
      else if (btn_left && !btn_right) x_s = x_s - STEP;
      if (x_s < X_LO)      x_d = 13'(X_LO);
      else if (x_s > X_HI) x_d = 13'(X_HI);
      else                 x_d = x_s[12:0];

      case (state_q)
        GROUNDED: begin
          if (armed_q && btn_jump) begin
            state_d      = RISING;
            vy_d         = VY_JUMP;
            jump_start_d = 1'b1;
            armed_d      = 1'b0;
          end
        end
        RISING: begin
          if (hit_now) begin
            state_d = FALLING;
            vy_d    = 4'd0;
          end else begin
            if (y_sub <= $signed({1'b0, Y_TOP})) y_d = Y_TOP;
            else                                 y_d = y_sub[9:0];
            vy_d = vy_dec;
            if (vy_dec == 4'd0 || y_d == Y_TOP) begin
              state_d = FALLING;
              vy_d    = 4'd0;
            end
          end
        end
        FALLING: begin
          if (y_add >= {1'b0, Y_GND}) begin
            y_d     = Y_GND;
            state_d = GROUNDED;
            vy_d    = 4'd0;
          end else begin
            y_d  = y_add[9:0];
            vy_d = (vy_q >= VY_TERM) ? VY_TERM : vy_q + 4'd1;
          end
        end
        default: begin
          state_d = GROUNDED;
          vy_d    = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= GROUNDED;
      x_q          <= X_RST;
      y_q          <= Y_GND;
      vy_q         <= 4'd0;
      hit_seen_q   <= 1'b0;
      armed_q      <= 1'b0;
      jump_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      vy_q         <= vy_d;
      hit_seen_q   <= hit_seen_d;
      armed_q      <= armed_d;
      jump_start_q <= jump_start_d;
    end
  end

  camera_offset #(
    .CAM_X   (CAM_X),
    .OFF_MAX (X_MAX + 1 - SCREEN_W)
  ) u_camera (
    .pixel_clk_in (pixel_clk_in),
    .rst_in       (rst_in),
    .x_in         (x_q),
    .offset_out   (offset)
  );

  assign x_mario_center = x_q;
  assign y_mario_center = y_q;
  assign state_out      = state_q;
  assign jump_start     = jump_start_q;

endmodule

// File: tb/tb_mario_motion.sv
// Directed bench for mario_motion: walking/clamping, jump arcs, head-bump aborts,
// button arming, back-to-back frames and asynchronous reset.
module tb_mario_motion;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        nf  = 1'b0;
  logic        bl  = 1'b0;
  logic        br  = 1'b0;
  logic        bj  = 1'b0;
  logic        hh  = 1'b0;
  logic [12:0] x;
  logic [9:0]  y;
  logic [11:0] off;
  logic [1:0]  st;
  logic        js;
  logic        js_seen;
  logic        js_after;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  mario_motion dut (
    .pixel_clk_in   (clk),
    .rst_in         (rst),
    .new_frame      (nf),
    .btn_left       (bl),
    .btn_right      (br),
    .btn_jump       (bj),
    .head_hit_in    (hh),
    .x_mario_center (x),
    .y_mario_center (y),
    .offset         (off),
    .state_out      (st),
    .jump_start     (js)
  );

  // hit_mode: 0 none, 1 hit coincident with new_frame, 2 hit in the cycle after.
  task automatic frame(input logic l, input logic r, input logic j, input int hit_mode);
    @(negedge clk);
    nf = 1'b1; bl = l; br = r; bj = j; hh = (hit_mode == 1);
    @(negedge clk);
    nf = 1'b0; hh = (hit_mode == 2); js_seen = js;
    @(negedge clk);
    hh = 1'b0; js_after = js;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; nf = 1'b0; bl = 1'b0; br = 1'b0; bj = 1'b0; hh = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++; if (x !== 13'd40) begin bad++; $display("FAIL reset_x got=%0d want=40", x); end
    total++; if (y !== 10'd223) begin bad++; $display("FAIL reset_y got=%0d want=223", y); end
    total++; if (off !== 12'd0) begin bad++; $display("FAIL reset_offset got=%0d want=0", off); end
    total++; if (st !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", st); end
    total++; if (js !== 1'b0) begin bad++; $display("FAIL reset_jump_start got=%0b want=0", js); end
    $display("reset: x=%0d y=%0d off=%0d st=%0d", x, y, off, st);
  endtask

  task automatic test_walk;
    do_reset();
    repeat (100) frame(1'b0, 1'b1, 1'b0, 0);
    total++; if (x !== 13'd240) begin bad++; $display("FAIL walk100_x got=%0d want=240", x); end
    total++; if (off !== 12'd80) begin bad++; $display("FAIL walk100_offset got=%0d want=80", off); end
    $display("walk right x100: x=%0d off=%0d", x, off);
    frame(1'b1, 1'b1, 1'b0, 0);
    total++; if (x !== 13'd240) begin bad++; $display("FAIL both_hold got=%0d want=240", x); end
    frame(1'b0, 1'b0, 1'b0, 0);
    total++; if (x !== 13'd240) begin bad++; $display("FAIL none_hold got=%0d want=240", x); end
    repeat (1570) frame(1'b0, 1'b1, 1'b0, 0);
    total++; if (x !== 13'd3371) begin bad++; $display("FAIL right_clamp_x got=%0d want=3371", x); end
    total++; if (off !== 12'd3056) begin bad++; $display("FAIL right_clamp_offset got=%0d want=3056", off); end
    $display("right clamp: x=%0d off=%0d", x, off);
    frame(1'b1, 1'b0, 1'b0, 0);
    total++; if (x !== 13'd3369) begin bad++; $display("FAIL left_step_x got=%0d want=3369", x); end
    total++; if (off !== 12'd3056) begin bad++; $display("FAIL left_step_offset got=%0d want=3056", off); end
    do_reset();
    repeat (25) frame(1'b1, 1'b0, 1'b0, 0);
    total++; if (x !== 13'd4) begin bad++; $display("FAIL left_clamp_x got=%0d want=4", x); end
    total++; if (off !== 12'd0) begin bad++; $display("FAIL left_clamp_offset got=%0d want=0", off); end
    $display("left clamp: x=%0d off=%0d", x, off);
  endtask

  task automatic test_jump;
    int ys  [22] = '{213, 204, 196, 189, 183, 178, 174, 171, 169, 168,
                     168, 169, 171, 174, 178, 183, 189, 196, 204, 212, 220, 223};
    int sts [22] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 2,
                     2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 0};
    int js_count;
    do_reset();
    frame(1'b0, 1'b0, 1'b0, 0);
    frame(1'b0, 1'b0, 1'b1, 0);
    total++; if (js_seen !== 1'b1) begin bad++; $display("FAIL jump_pulse got=%0b want=1", js_seen); end
    total++; if (js_after !== 1'b0) begin bad++; $display("FAIL jump_pulse_width got=%0b want=0", js_after); end
    total++; if (st !== 2'd1 || y !== 10'd223) begin
      bad++; $display("FAIL jump_start_frame got st=%0d y=%0d want st=1 y=223", st, y);
    end
    js_count = 0;
    for (int i = 0; i < 22; i++) begin
      frame(1'b0, 1'b0, 1'b1, 0);
      js_count += int'(js_seen);
      total++;
      if (y !== 10'(ys[i]) || st !== 2'(sts[i])) begin
        bad++; $display("FAIL jump_arc[%0d] got y=%0d st=%0d want y=%0d st=%0d", i, y, st, ys[i], sts[i]);
      end
      $display("jump frame %0d: y=%0d st=%0d", i, y, st);
    end
    repeat (3) begin
      frame(1'b0, 1'b0, 1'b1, 0);
      js_count += int'(js_seen);
    end
    total++; if (js_count !== 0 || st !== 2'd0) begin
      bad++; $display("FAIL held_no_rejump got pulses=%0d st=%0d want pulses=0 st=0", js_count, st);
    end
    frame(1'b0, 1'b0, 1'b0, 0);
    frame(1'b0, 1'b0, 1'b1, 0);
    total++; if (js_seen !== 1'b1 || st !== 2'd1) begin
      bad++; $display("FAIL rejump got pulse=%0b st=%0d want pulse=1 st=1", js_seen, st);
    end
    $display("rejump: pulse=%0b st=%0d", js_seen, st);
  endtask

  task automatic test_head_hit;
    int ys [4] = '{204, 205, 207, 210};
    do_reset();
    frame(1'b0, 1'b0, 1'b0, 0);
    frame(1'b0, 1'b0, 1'b1, 0);
    frame(1'b0, 1'b0, 1'b1, 0);
    frame(1'b0, 1'b0, 1'b1, 2);
    total++; if (y !== 10'd204 || st !== 2'd1) begin
      bad++; $display("FAIL hit_late_no_effect got y=%0d st=%0d want y=204 st=1", y, st);
    end
    frame(1'b0, 1'b0, 1'b1, 0);
    total++; if (y !== 10'd204 || st !== 2'd2) begin
      bad++; $display("FAIL hit_abort got y=%0d st=%0d want y=204 st=2", y, st);
    end
    $display("head hit abort: y=%0d st=%0d", y, st);
    for (int i = 0; i < 4; i++) begin
      frame(1'b0, 1'b0, 1'b1, 0);
      total++;
      if (y !== 10'(ys[i]) || st !== 2'd2) begin
        bad++; $display("FAIL hit_fall[%0d] got y=%0d st=%0d want y=%0d st=2", i, y, st, ys[i]);
      end
    end
  endtask

  task automatic test_coincident;
    do_reset();
    frame(1'b0, 1'b0, 1'b0, 0);
    frame(1'b0, 1'b0, 1'b1, 0);
    frame(1'b0, 1'b0, 1'b1, 0);
    frame(1'b0, 1'b0, 1'b1, 1);
    total++; if (y !== 10'd213 || st !== 2'd2) begin
      bad++; $display("FAIL hit_coincident got y=%0d st=%0d want y=213 st=2", y, st);
    end
    $display("coincident hit: y=%0d st=%0d", y, st);
    do_reset();
    frame(1'b0, 1'b0, 1'b0, 2);
    frame(1'b0, 1'b0, 1'b1, 0);
    frame(1'b0, 1'b0, 1'b1, 0);
    total++; if (y !== 10'd213 || st !== 2'd1) begin
      bad++; $display("FAIL hit_grounded_discard got y=%0d st=%0d want y=213 st=1", y, st);
    end
    $display("grounded hit discarded: y=%0d st=%0d", y, st);
  endtask

  task automatic test_back_to_back;
    do_reset();
    frame(1'b0, 1'b0, 1'b0, 0);
    @(negedge clk);
    nf = 1'b1; bj = 1'b1;
    @(negedge clk);
    total++; if (js !== 1'b1 || st !== 2'd1 || y !== 10'd223) begin
      bad++; $display("FAIL b2b_first got js=%0b st=%0d y=%0d want js=1 st=1 y=223", js, st, y);
    end
    @(negedge clk);
    nf = 1'b0;
    total++; if (js !== 1'b0 || st !== 2'd1 || y !== 10'd213) begin
      bad++; $display("FAIL b2b_second got js=%0b st=%0d y=%0d want js=0 st=1 y=213", js, st, y);
    end
    $display("back to back: st=%0d y=%0d", st, y);
  endtask

  task automatic test_reset_mid;
    do_reset();
    repeat (100) frame(1'b0, 1'b1, 1'b0, 0);
    frame(1'b0, 1'b1, 1'b1, 0);
    repeat (3) frame(1'b0, 1'b1, 1'b1, 0);
    total++; if (y !== 10'd196 || x !== 13'd248 || off !== 12'd88) begin
      bad++; $display("FAIL pre_reset got y=%0d x=%0d off=%0d want y=196 x=248 off=88", y, x, off);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (x !== 13'd40 || y !== 10'd223 || off !== 12'd0 || st !== 2'd0 || js !== 1'b0) begin
      bad++; $display("FAIL async_reset got x=%0d y=%0d off=%0d st=%0d js=%0b", x, y, off, st, js);
    end
    repeat (3) begin
      @(negedge clk); nf = 1'b1; br = 1'b1; bj = 1'b1;
      @(negedge clk); nf = 1'b0;
    end
    total++; if (x !== 13'd40 || y !== 10'd223 || off !== 12'd0 || st !== 2'd0 || js !== 1'b0) begin
      bad++; $display("FAIL reset_hold got x=%0d y=%0d off=%0d st=%0d js=%0b", x, y, off, st, js);
    end
    rst = 1'b0;
    frame(1'b0, 1'b0, 1'b1, 0);
    total++; if (st !== 2'd0 || js_seen !== 1'b0) begin
      bad++; $display("FAIL reset_disarms got st=%0d pulse=%0b want st=0 pulse=0", st, js_seen);
    end
    $display("mid-jump reset: x=%0d y=%0d st=%0d", x, y, st);
  endtask

  initial begin
    test_reset();
    test_walk();
    test_jump();
    test_head_hit();
    test_coincident();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
